// File: rtl/data_memory_arbiter.sv
// Two-master burst arbiter in front of the single-port byte data memory.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking; otherwise m0 has fixed priority.
module data_memory_arbiter #(
    parameter int unsigned N    = 16,
    parameter int unsigned BITS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m0_req,
    input  logic            m0_we,
    input  logic [N-1:0]    m0_addr,
    input  logic [3:0]      m0_len,
    input  logic [BITS-1:0] m0_wdata,
    output logic            m0_gnt,
    output logic            m0_beat,
    output logic            m0_done,
    output logic            m0_rvalid,
    output logic [BITS-1:0] m0_rdata,
    input  logic            m1_req,
    input  logic            m1_we,
    input  logic [N-1:0]    m1_addr,
    input  logic [3:0]      m1_len,
    input  logic [BITS-1:0] m1_wdata,
    output logic            m1_gnt,
    output logic            m1_beat,
    output logic            m1_done,
    output logic            m1_rvalid,
    output logic [BITS-1:0] m1_rdata,
    output logic [N-1:0]    mem_address,
    output logic            mem_we,
    output logic [BITS-1:0] mem_wdata,
    input  logic [BITS-1:0] mem_read_data
);

    typedef enum logic {StIdle, StBurst} state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            we_q, we_d;
    logic [N-1:0]    base_q, base_d;
    logic [3:0]      len_q, len_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            rvalid0_q, rvalid1_q;
    logic [BITS-1:0] rdata0_q, rdata1_q;
    logic            pick;
    logic            read_beat;

`ifdef DMEM_ARB_RR_EN
    logic last_q, last_d;
    assign pick = (m0_req && m1_req) ? !last_q : !m0_req;
`else
    assign pick = !m0_req;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        base_d      = base_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
`ifdef DMEM_ARB_RR_EN
        last_d      = last_q;
`endif
        m0_gnt      = 1'b0;
        m0_beat     = 1'b0;
        m0_done     = 1'b0;
        m1_gnt      = 1'b0;
        m1_beat     = 1'b0;
        m1_done     = 1'b0;
        mem_address = '0;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        read_beat   = 1'b0;
        case (state_q)
            StIdle: begin
                if (m0_req || m1_req) begin
                    owner_d = pick;
                    we_d    = pick ? m1_we : m0_we;
                    base_d  = pick ? m1_addr : m0_addr;
                    len_d   = pick ? m1_len : m0_len;
                    cnt_d   = 4'd0;
                    state_d = StBurst;
`ifdef DMEM_ARB_RR_EN
                    last_d  = pick;
`endif
                end
            end
            StBurst: begin
                mem_address = base_q + N'({cnt_q, 2'b00});
                // Gated by reset so an aborted burst never writes on the reset edge.
                mem_we      = we_q && rst_n;
                mem_wdata   = owner_q ? m1_wdata : m0_wdata;
                read_beat   = !we_q;
                m0_beat     = !owner_q;
                m1_beat     = owner_q;
                m0_gnt      = !owner_q && (cnt_q == 4'd0);
                m1_gnt      = owner_q && (cnt_q == 4'd0);
                m0_done     = !owner_q && (cnt_q == len_q);
                m1_done     = owner_q && (cnt_q == len_q);
                if (cnt_q == len_q) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            owner_q   <= 1'b0;
            we_q      <= 1'b0;
            base_q    <= '0;
            len_q     <= 4'd0;
            cnt_q     <= 4'd0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
`ifdef DMEM_ARB_RR_EN
            last_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            base_q    <= base_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            rvalid0_q <= read_beat && !owner_q;
            rvalid1_q <= read_beat && owner_q;
            if (read_beat && !owner_q) rdata0_q <= mem_read_data;
            if (read_beat && owner_q) rdata1_q <= mem_read_data;
`ifdef DMEM_ARB_RR_EN
            last_q    <= last_d;
`endif
        end
    end

    assign m0_rvalid = rvalid0_q;
    assign m1_rvalid = rvalid1_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: byte memory, queue-of-beats reference model and directed tests.
module tb_data_memory_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [15:0] m0_addr, m1_addr;
    logic [3:0]  m0_len, m1_len;
    logic [31:0] m0_wdata, m1_wdata;
    logic        m0_gnt, m0_beat, m0_done, m0_rvalid;
    logic        m1_gnt, m1_beat, m1_done, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [15:0] mem_address;
    logic        mem_we;
    logic [31:0] mem_wdata, mem_read_data;

    int checks = 0;
    int errors = 0;

    data_memory_arbiter #(.N(16), .BITS(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_len(m0_len),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_beat(m0_beat), .m0_done(m0_done),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_len(m1_len),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_beat(m1_beat), .m1_done(m1_done),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_address(mem_address), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Byte memory driven by the DUT, and an independent shadow kept by the model.
    logic [7:0] mem    [0:65535];
    logic [7:0] shadow [0:65535];
    assign mem_read_data = {24'b0, mem[mem_address]};
    always @(posedge clk) if (mem_we) mem[mem_address] <= mem_wdata[7:0];

    typedef struct packed {
        logic        owner;
        logic        we;
        logic [15:0] addr;
        logic        first;
        logic        last;
    } beat_t;

    beat_t       q[$];
    logic        exp_rv [2];
    logic [31:0] exp_rd [2];
    bit          model_ok = 0;
    bit          last_owner = 1;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: a granted burst becomes a list of beats; one beat retires per cycle.
    always @(posedge clk) begin
        beat_t       b;
        logic        w;
        logic [31:0] wd;
        logic [15:0] base;
        int          n;
        if (!rst_n) begin
            q.delete();
            exp_rv[0] = 0; exp_rv[1] = 0;
            exp_rd[0] = 0; exp_rd[1] = 0;
            last_owner = 1;
            model_ok = 1;
        end else if (q.size() == 0) begin
            exp_rv[0] = 0; exp_rv[1] = 0;
            if (m0_req || m1_req) begin
`ifdef DMEM_ARB_RR_EN
                w = (m0_req && m1_req) ? !last_owner : !m0_req;
`else
                w = !m0_req;
`endif
                last_owner = w;
                base = w ? m1_addr : m0_addr;
                n = int'(w ? m1_len : m0_len) + 1;
                for (int i = 0; i < n; i++) begin
                    b.owner = w;
                    b.we    = w ? m1_we : m0_we;
                    b.addr  = base + 16'(4 * i);
                    b.first = (i == 0);
                    b.last  = (i == n - 1);
                    q.push_back(b);
                end
            end
        end else begin
            b = q.pop_front();
            exp_rv[0] = 0; exp_rv[1] = 0;
            if (b.we) begin
                wd = b.owner ? m1_wdata : m0_wdata;
                shadow[b.addr] = wd[7:0];
            end else begin
                exp_rv[b.owner] = 1;
                exp_rd[b.owner] = {24'b0, shadow[b.addr]};
            end
        end
    end

    always @(negedge clk) begin
        logic [120:0] got_v, exp_v;
        logic         eg[2], eb[2], ed[2];
        logic [15:0]  ea;
        logic         ewe;
        logic [31:0]  ewd;
        beat_t        f;
        if (model_ok) begin
            eg[0] = 0; eg[1] = 0; eb[0] = 0; eb[1] = 0; ed[0] = 0; ed[1] = 0;
            ea = 0; ewe = 0; ewd = 0;
            if (q.size() > 0) begin
                f = q[0];
                eb[f.owner] = 1;
                eg[f.owner] = f.first;
                ed[f.owner] = f.last;
                ea  = f.addr;
                ewe = f.we && rst_n;
                ewd = f.owner ? m1_wdata : m0_wdata;
            end
            got_v = {m0_gnt, m0_beat, m0_done, m0_rvalid, m0_rdata,
                     m1_gnt, m1_beat, m1_done, m1_rvalid, m1_rdata,
                     mem_address, mem_we, mem_wdata};
            exp_v = {eg[0], eb[0], ed[0], exp_rv[0], exp_rd[0],
                     eg[1], eb[1], ed[1], exp_rv[1], exp_rd[1],
                     ea, ewe, ewd};
            chk("cycle", {7'b0, got_v}, {7'b0, exp_v});
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Tie between m0 and m1 (len=1 reads); w is the master expected to win.
    task automatic tie(input bit w);
        tick();
        m0_we = 0; m0_addr = 16'h0200; m0_len = 4'd1;
        m1_we = 0; m1_addr = 16'h0300; m1_len = 4'd1;
        m0_req = 1; m1_req = 1;
        tick();
        if (w) m1_req = 0; else m0_req = 0;
        @(negedge clk); chk("tie_first_gnt", {126'b0, m0_gnt, m1_gnt}, w ? 128'h1 : 128'h2);
        @(negedge clk); chk("tie_first_done", {126'b0, m0_done, m1_done}, w ? 128'h1 : 128'h2);
        @(negedge clk); chk("tie_turnaround", {126'b0, m0_beat, m1_beat}, 128'h0);
        tick();
        if (w) m0_req = 0; else m1_req = 0;
        @(negedge clk); chk("tie_second_gnt", {126'b0, m0_gnt, m1_gnt}, w ? 128'h2 : 128'h1);
        @(negedge clk); chk("tie_second_done", {126'b0, m0_done, m1_done}, w ? 128'h2 : 128'h1);
    endtask

    initial begin
        logic [15:0] wrap_addr [4];
        int          m1_grants;
        wrap_addr[0] = 16'hFFF8; wrap_addr[1] = 16'hFFFC;
        wrap_addr[2] = 16'h0000; wrap_addr[3] = 16'h0004;
        for (int i = 0; i < 65536; i++) begin
            mem[i]    = 8'(i) ^ 8'h5A;
            shadow[i] = 8'(i) ^ 8'h5A;
        end
        rst_n = 0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_len = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_len = 0; m1_wdata = 0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_outputs", {56'b0, m0_gnt, m0_beat, m1_gnt, m1_beat, mem_we, mem_address,
            m0_rdata, m1_rdata}, 128'h0);
        tick();
        rst_n = 1;

        // T1: m0 read of four beats from 0x10
        tick();
        m0_we = 0; m0_addr = 16'h0010; m0_len = 4'd3; m0_req = 1;
        tick();
        m0_req = 0;
        @(negedge clk); chk("t1_gnt_addr", {111'b0, m0_gnt, mem_address}, {111'b0, 1'b1, 16'h0010});
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            chk("t1_addr", {112'b0, mem_address}, {112'b0, 16'h0010 + 16'(4 * i)});
        end
        chk("t1_done", {127'b0, m0_done}, 128'h1);
        @(negedge clk); chk("t1_last_rdata", {95'b0, m0_rvalid, m0_rdata}, {95'b0, 1'b1, 32'h46});

        // T2: m1 single-beat write of 0xA5, read back by m0
        tick();
        m1_we = 1; m1_addr = 16'h0100; m1_len = 4'd0; m1_wdata = 32'h0000_00A5; m1_req = 1;
        tick();
        m1_req = 0;
        @(negedge clk);
        chk("t2_write_beat", {101'b0, m1_gnt, m1_done, mem_we, mem_address, mem_wdata[7:0]},
            {101'b0, 1'b1, 1'b1, 1'b1, 16'h0100, 8'hA5});
        tick();
        m0_we = 0; m0_addr = 16'h0100; m0_len = 4'd0; m0_req = 1;
        tick();
        m0_req = 0;
        @(negedge clk);
        @(negedge clk); chk("t2_readback", {95'b0, m0_rvalid, m0_rdata}, {95'b0, 1'b1, 32'hA5});

        // T3: two ties; last grant before them was m0
`ifdef DMEM_ARB_RR_EN
        tie(1'b1);
        tie(1'b1);
`else
        tie(1'b0);
        tie(1'b0);
`endif

        // T4: address wrap
        tick();
        m0_we = 0; m0_addr = 16'hFFF8; m0_len = 4'd3; m0_req = 1;
        tick();
        m0_req = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_wrap_addr", {112'b0, mem_address}, {112'b0, wrap_addr[i]});
        end
        @(negedge clk);

        // T5: reset during beat 2 of an 8-beat write
        tick();
        m0_we = 1; m0_addr = 16'h0400; m0_len = 4'd7; m0_wdata = 32'h0000_003C; m0_req = 1;
        tick();
        m0_req = 0;
        tick();
        tick();
        rst_n = 0;
        @(negedge clk); chk("t5_we_in_reset", {127'b0, mem_we}, 128'h0);
        tick();
        rst_n = 1;
        @(negedge clk);
        chk("t5_after_reset", {74'b0, m0_gnt, m0_beat, m0_done, m0_rvalid, mem_we, mem_address,
            m0_rdata}, 128'h0);
        chk("t5_mem_beats", {96'b0, mem[16'h0400], mem[16'h0404], mem[16'h0408], mem[16'h041C]},
            {96'b0, 8'h3C, 8'h3C, 8'h52, 8'h46});

        // T6: transient m1 request during an m0 burst is never granted
        tick();
        m0_we = 0; m0_addr = 16'h0500; m0_len = 4'd3; m0_req = 1;
        tick();
        m0_req = 0;
        tick();
        m1_we = 0; m1_addr = 16'h0600; m1_len = 4'd0; m1_req = 1;
        tick();
        m1_req = 0;
        m1_grants = 0;
        repeat (8) begin
            @(negedge clk);
            if (m1_gnt) m1_grants++;
        end
        chk("t6_no_m1_grant", 128'(m1_grants), 128'h0);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
